// File: rtl/latch_piso_tx.sv
// latch_piso_tx: parallel-in / serial-out transmitter.
//
// Accepts a WIDTH-bit word on a valid/ready handshake and sends it as a frame:
// start bit (0), data bits LSB first, optional even-parity bit, stop bit (1).
// Each serial bit lasts DIV clock cycles.
//
// Optional feature: define LATCH_PISO_PARITY_EN to insert a parity bit
// (XOR of the captured data) between the last data bit and the stop bit.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   load_valid in   upstream has a word on D
//   load_ready out  block can accept a word (IDLE only)
//   D          in   parallel data word [WIDTH-1:0]
//   ser_out    out  serial line, idles high (registered)
//   busy       out  frame in progress
//   done       out  one-cycle pulse in the first IDLE cycle after the stop bit
module latch_piso_tx #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] D,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef LATCH_PISO_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic              ser_q, ser_d;
    logic              done_q, done_d;
`ifdef LATCH_PISO_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic div_last;
    logic bit_last;

    assign div_last = (div_q == DivLast);
    assign bit_last = (bit_q == BitLast);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
        ser_d    = 1'b1;
`ifdef LATCH_PISO_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (load_valid) begin
                    shift_d  = D;
                    div_d    = '0;
                    bit_d    = '0;
                    state_d  = StStart;
`ifdef LATCH_PISO_PARITY_EN
                    parity_d = ^D;
`endif
                end
            end
            StStart: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = StData;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StData: begin
                if (div_last) begin
                    div_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_last) begin
                        bit_d   = '0;
`ifdef LATCH_PISO_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
`ifdef LATCH_PISO_PARITY_EN
            StParity: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = StStop;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Line level is decoded from the next state so ser_out can be a flop
        // that already matches the state entered on the same edge.
        unique case (state_d)
            StStart:  ser_d = 1'b0;
            StData:   ser_d = shift_d[0];
`ifdef LATCH_PISO_PARITY_EN
            StParity: ser_d = parity_d;
`endif
            default:  ser_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            ser_q    <= 1'b1;
            done_q   <= 1'b0;
`ifdef LATCH_PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            ser_q    <= ser_d;
            done_q   <= done_d;
`ifdef LATCH_PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign ser_out    = ser_q;
    assign done       = done_q;
    assign busy       = (state_q != StIdle);
    assign load_ready = (state_q == StIdle);

endmodule

// File: tb/tb_latch_piso_tx.sv
// Bench for latch_piso_tx: directed and random frames checked against a
// frame-level model (list of bit values, each lasting DIV cycles).
module tb_latch_piso_tx;

    localparam int W  = 3;
    localparam int DV = 4;

    typedef bit bits_q_t[$];

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] D = '0;
    logic         load_ready;
    logic         ser_out;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    latch_piso_tx #(
        .WIDTH(W),
        .DIV  (DV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .D         (D),
        .ser_out   (ser_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected serial frame as a list of bit values.
    function automatic bits_q_t frame_bits(input logic [W-1:0] d);
        bits_q_t q;
        q.push_back(1'b0);
        for (int i = 0; i < W; i++) q.push_back(d[i]);
`ifdef LATCH_PISO_PARITY_EN
        q.push_back(^d);
`endif
        q.push_back(1'b1);
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one word and check every cycle of the frame plus the done cycle.
    // keep: leave load_valid high at the end (back-to-back).
    // poke: pulse load_valid with another word while busy.
    task automatic frame(input logic [W-1:0] d, input bit keep, input bit poke);
        bits_q_t fb;
        int n;
        int guard;
        fb = frame_bits(d);
        n = fb.size() * DV;
        D = d;
        load_valid = 1'b1;
        guard = 0;
        while (!load_ready && guard < 200) begin
            tick();
            guard++;
        end
        chk("accept_ready", {31'd0, load_ready}, 32'd1);
        tick();
        if (!keep) load_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            chk("ser", {31'd0, ser_out}, {31'd0, fb[k / DV]});
            chk("busy", {31'd0, busy}, 32'd1);
            chk("ready_busy", {31'd0, load_ready}, 32'd0);
            chk("done_mid", {31'd0, done}, 32'd0);
            if (poke && k == 6) begin
                load_valid = 1'b1;
                D = W'(3'b010);
            end else if (poke && k == 7) begin
                load_valid = 1'b0;
            end else if (!keep) begin
                D = W'($urandom);
            end
            tick();
        end
        chk("done", {31'd0, done}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ready", {31'd0, load_ready}, 32'd1);
        chk("idle_ser", {31'd0, ser_out}, 32'd1);
    endtask

    initial begin
        // Reset and idle.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ser", {31'd0, ser_out}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, load_ready}, 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_stable", {28'd0, ser_out, busy, done, load_ready}, 32'b1001);
        end

        // Single frame with a busy-time poke that must be ignored.
        frame(3'b101, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_second_frame", {29'd0, ser_out, busy, done}, 32'b100);
        end

        // Back-to-back frames.
        frame(3'b011, 1'b1, 1'b0);
        frame(3'b100, 1'b0, 1'b0);
        tick();
        chk("b2b_done_clear", {31'd0, done}, 32'd0);

        // Reset during the second data bit.
        D = 3'b110;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (9) tick();
        chk("pre_rst_bit1", {31'd0, ser_out}, 32'd1);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_ser", {31'd0, ser_out}, 32'd1);
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_ready", {31'd0, load_ready}, 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_idle", {29'd0, ser_out, busy, done}, 32'b100);
        end
        frame(3'b111, 1'b0, 1'b0);

`ifdef LATCH_PISO_PARITY_EN
        frame(3'b101, 1'b0, 1'b0);
        frame(3'b111, 1'b0, 1'b0);
`endif

        // Random words with random idle gaps.
        for (int i = 0; i < 12; i++) begin
            frame(W'($urandom), 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/latch_piso_tx.md
Name: latch_piso_tx

Overview:
- Transmit-side counterpart to the lab's D-latch storage blocks.
- Captures a parallel WIDTH-bit word through a valid/ready handshake, then shifts it out serially on a single line.
- Frame: start bit (0), data bits LSB first, stop bit (1).
- Bit timing comes from an internal clock divider, so a downstream serial receiver or LED/scope probe sees a fixed-rate stream.

Parameters:
- WIDTH, 3, data word width in bits (≥1).
- DIV, 4, clock cycles per serial bit (≥1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  upstream asserts when D holds a word to send.
- load_ready  output  1  block can accept a word this cycle.
- D  input  WIDTH  parallel data word.
- ser_out  output  1  serial line; idles high.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; shift register and bit/divider counters clear to 0.
  - Outputs: ser_out=1, busy=0, done=0, load_ready=1.
  - Takes effect immediately, including mid-frame. The frame is abandoned and nothing is resumed after rst_n rises.
- Handshake:
  - load_ready=1 only in IDLE.
  - A transfer occurs on a rising edge with load_valid=1 and load_ready=1. D is copied into the shift register on that edge.
  - load_valid while busy is ignored; the word is not queued.
  - D changes after capture have no effect on the frame.
- States:
  - IDLE: ser_out=1. On transfer go to START, with divider=0 and bit counter=0.
  - START: ser_out=0 for DIV cycles, then DATA.
  - DATA: ser_out=shift_reg[0].
    - Every DIV cycles, shift right by one and increment the bit counter.
    - After WIDTH bits go to STOP (or PARITY when the optional feature is enabled).
  - STOP: ser_out=1 for DIV cycles, then IDLE.
- Divider:
  - Counts 0..DIV-1 and wraps; the bit boundary is at DIV-1.
  - DIV=1 gives one bit per cycle.
- Timing:
  - ser_out first goes low the cycle after the accepting edge.
  - Frame length is (WIDTH+2)*DIV cycles.
  - done=1 for exactly the first IDLE cycle after STOP.
  - load_ready is also 1 in that cycle, so back-to-back frames have only 1 idle-high cycle between stop and the next start.
- busy=1 in START/DATA/STOP (and PARITY), 0 in IDLE.
- Outputs are registered where they drive ser_out, so there are no glitches on the line.

Optional Feature:
- Macro: LATCH_PISO_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - ser_out = even parity (XOR of all captured data bits) for DIV cycles.
  - Frame length becomes (WIDTH+3)*DIV cycles.
- Undefined: no PARITY state or logic; the frame is exactly as described above.

Test Plan:
- Reset idle: hold rst_n=0 then release with load_valid=0 → ser_out=1, load_ready=1, busy=0, done=0, stable for 20 cycles.
- Single frame: WIDTH=3, DIV=4, D=3'b101 accepted at edge t0.
  - ser_out per 4-cycle slot: 0,1,0,1,1.
  - busy high for 20 cycles.
  - done pulses at cycle t0+21.
- Busy rejection: during the frame above, pulse load_valid with D=3'b010 → load_ready=0, stream unchanged, no second frame.
- Back-to-back: load_valid held high, D=3'b011 then 3'b100.
  - Second start bit begins 1 cycle after done.
  - Sequences 0,1,1,0,1 and 0,0,0,1,1.
- Reset mid-frame: assert rst_n=0 during the 2nd data bit → ser_out=1 and busy=0 immediately (async). After release, a new D=3'b111 sends a full, correct frame.
- Parity (LATCH_PISO_PARITY_EN defined):
  - D=3'b101 → slots 0,1,0,1,0,1.
  - D=3'b111 → slots 0,1,1,1,1,1.
  - Frame is 24 cycles with DIV=4.
